// File: rtl/nbcac_encoder_stream_20_if.sv
// rtl/nbcac_encoder_stream_20_if.sv - data-in and codeword-out handshake bundle for the NBCAC stream encoder

interface nbcac_encoder_stream_20_if #(
  parameter int DATA_W = 14,
  parameter int CODE_W = 20,
  parameter int CNT_W  = 16
);
  logic [DATA_W-1:0] datain;
  logic              data_valid;
  logic              data_ready;
  logic [CODE_W:1]   codeout;
  logic              code_valid;
  logic              code_ready;
  logic [CNT_W-1:0]  code_count;

  // Word source and link driver side
  modport master (
    output datain, data_valid, code_ready,
    input  data_ready, codeout, code_valid, code_count
  );

  // Encoder side
  modport slave (
    input  datain, data_valid, code_ready,
    output data_ready, codeout, code_valid, code_count
  );
endinterface

// File: rtl/nbcac_encoder_stream_20.sv
// rtl/nbcac_encoder_stream_20.sv - two-stage streaming NBCAC encoder with handoff counter

// Fibonacci-weighted crosstalk-avoidance code: wire k carries weight
// 1,2,3,5,8,... (weight k = weight k-1 + weight k-2). The greedy
// most-significant-first pick yields the unique codeword with no two
// adjacent ones, and the data word is the weighted sum of the set wires.
module nbcac_14di_encoder_core (
  input  logic [13:0] v,
  output logic [20:1] d
);
  localparam logic [14:0] WEIGHT [1:20] = '{
    15'd1,    15'd2,    15'd3,    15'd5,    15'd8,
    15'd13,   15'd21,   15'd34,   15'd55,   15'd89,
    15'd144,  15'd233,  15'd377,  15'd610,  15'd987,
    15'd1597, 15'd2584, 15'd4181, 15'd6765, 15'd10946
  };

  logic [14:0] rem;

  // Greedy Fibonacci decomposition from the heaviest wire down
  always_comb begin
    d   = '0;
    rem = {1'b0, v};
    for (int k = 20; k >= 1; k--) begin
      if (rem >= WEIGHT[k]) begin
        d[k] = 1'b1;
        rem  = rem - WEIGHT[k];
      end
    end
  end
endmodule

module nbcac_encoder_stream_20 #(
  parameter int DATA_W = 14,
  parameter int CODE_W = 20,
  parameter int CNT_W  = 16
) (
  input  logic                      clock,
  input  logic                      rst_n,
  input  logic                      flush,
  nbcac_encoder_stream_20_if.slave  bus
);
  logic [DATA_W-1:0] s1_data;
  logic              s1_valid;
  logic [CODE_W:1]   enc_word;
  logic [CODE_W:1]   codeout_q;
  logic              code_valid_q;
  logic [CNT_W-1:0]  count_q;
  logic              s1_load;
  logic              s2_load;
  logic              handoff;

  nbcac_14di_encoder_core u_core (
    .v (s1_data),
    .d (enc_word)
  );

  // s2 refills whenever it is empty or draining this cycle; s1 refills
  // whenever it is empty or moving into s2, giving full throughput.
  assign s2_load = s1_valid & (~code_valid_q | bus.code_ready);
  assign s1_load = ~s1_valid | s2_load;
  assign handoff = code_valid_q & bus.code_ready;

  assign bus.data_ready = s1_load & ~flush;
  assign bus.codeout    = codeout_q;
  assign bus.code_valid = code_valid_q;
  assign bus.code_count = count_q;

  // Stage 1: capture the incoming word; flush only drops the valid
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (s1_load) begin
      s1_data  <= bus.datain;
      s1_valid <= bus.data_valid;
    end
  end

  // Stage 2: register the codeword; it stays on the wires when idle
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      codeout_q    <= '0;
      code_valid_q <= 1'b0;
    end else if (flush) begin
      code_valid_q <= 1'b0;
    end else if (s2_load) begin
      codeout_q    <= enc_word;
      code_valid_q <= 1'b1;
    end else if (handoff) begin
      code_valid_q <= 1'b0;
    end
  end

  // Count every codeword the link driver takes, including in a flush cycle
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (handoff) begin
      count_q <= count_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_nbcac_encoder_stream_20.sv
// tb/tb_nbcac_encoder_stream_20.sv - self-checking bench for the NBCAC stream encoder

module tb_nbcac_encoder_stream_20;
  logic clock = 1'b0;
  logic rst_n;
  logic flush;

  nbcac_encoder_stream_20_if              bus ();
  nbcac_encoder_stream_20_if #(.CNT_W(4)) bus4 ();

  nbcac_encoder_stream_20 dut (
    .clock (clock),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus.slave)
  );

  nbcac_encoder_stream_20 #(.CNT_W(4)) dut4 (
    .clock (clock),
    .rst_n (rst_n),
    .flush (1'b0),
    .bus   (bus4.slave)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  logic [13:0] exp_q[$];
  int exp_count;
  bit acc;

  // Weighted sum of set wires, weights 1,2,3,5,8,...
  function automatic int decode(input logic [20:1] c);
    int a = 1;
    int b = 2;
    int s = 0;
    int t;
    for (int k = 1; k <= 20; k++) begin
      if (c[k]) s += a;
      t = a + b;
      a = b;
      b = t;
    end
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: score handoffs/accepts seen just before the edge, then advance
  task automatic tick();
    logic [13:0] w;
    bit fl;
    #1;
    fl  = flush;
    acc = bus.data_valid && bus.data_ready;
    if (bus.code_valid && bus.code_ready) begin
      chk("handoff_pending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        chk("order_roundtrip", decode(bus.codeout), w);
      end
      exp_count++;
    end
    if (acc) exp_q.push_back(bus.datain);
    @(posedge clock);
    #1;
    if (fl) exp_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    @(posedge clock);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    exp_count = 0;
  endtask

  initial begin
    logic [13:0] words [0:2];
    logic [20:1] held;
    logic [13:0] r;
    int idx;

    rst_n = 1'b0;
    flush = 1'b0;
    bus.datain = '0;  bus.data_valid = 1'b0;  bus.code_ready = 1'b1;
    bus4.datain = '0; bus4.data_valid = 1'b0; bus4.code_ready = 1'b1;
    exp_count = 0;
    #12;
    chk("rst_codeout", bus.codeout, 0);
    chk("rst_code_valid", bus.code_valid, 0);
    chk("rst_code_count", bus.code_count, 0);
    chk("rst_data_ready", bus.data_ready, 1);
    @(posedge clock);
    #1;
    rst_n = 1'b1;

    // Single words with latency check
    bus.datain = 14'h0000; bus.data_valid = 1'b1;
    tick();
    bus.data_valid = 1'b0;
    chk("lat0_not_yet", bus.code_valid, 0);
    tick();
    chk("lat0_valid", bus.code_valid, 1);
    chk("lat0_decode", decode(bus.codeout), 14'h0000);
    bus.datain = 14'h3FFF; bus.data_valid = 1'b1;
    tick();
    bus.data_valid = 1'b0;
    chk("lat1_not_yet", bus.code_valid, 0);
    tick();
    chk("lat1_valid", bus.code_valid, 1);
    chk("lat1_decode", decode(bus.codeout), 14'h3FFF);
    tick();
    chk("single_count", bus.code_count, 2);

    // Exhaustive back-to-back stream
    do_reset();
    for (int i = 0; i < 16384; i++) begin
      bus.datain = 14'(i); bus.data_valid = 1'b1;
      #1;
      chk("stream_ready", bus.data_ready, 1);
      if (i >= 2) chk("stream_valid", bus.code_valid, 1);
      tick();
    end
    bus.data_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("stream_count", bus.code_count, 16'h4000);
    chk("stream_model_count", bus.code_count, 16'(exp_count));
    chk("stream_drained", exp_q.size(), 0);

    // Backpressure: only two words absorbed, head codeword held
    words[0] = 14'h0001; words[1] = 14'h0002; words[2] = 14'h0003;
    bus.code_ready = 1'b0;
    idx = 0;
    held = '0;
    for (int c = 0; c < 5; c++) begin
      bus.data_valid = 1'b1; bus.datain = words[idx];
      tick();
      if (acc) idx++;
      if (c == 1) held = bus.codeout;
      if (c >= 1) chk("bp_head_decode", decode(bus.codeout), 1);
      if (c >= 2) chk("bp_hold", bus.codeout, held);
    end
    #1;
    chk("bp_accepted", idx, 2);
    chk("bp_ready_low", bus.data_ready, 0);
    bus.code_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      bus.data_valid = (idx < 3);
      if (idx < 3) bus.datain = words[idx];
      tick();
      if (acc) idx++;
    end
    chk("bp_all_sent", idx, 3);
    chk("bp_drained", exp_q.size(), 0);
    chk("bp_count", bus.code_count, 16'(exp_count));

    // Idle hold
    bus.datain = 14'h2AAA; bus.data_valid = 1'b1;
    tick();
    bus.data_valid = 1'b0;
    tick();
    tick();
    held = bus.codeout;
    chk("idle_decode", decode(held), 14'h2AAA);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("idle_valid", bus.code_valid, 0);
      chk("idle_hold", bus.codeout, held);
    end

    // Flush with two words in flight
    bus.code_ready = 1'b0;
    bus.data_valid = 1'b1;
    r = 14'($urandom_range(0, 16383)); bus.datain = r;
    tick();
    r = 14'($urandom_range(0, 16383)); bus.datain = r;
    tick();
    held = bus.codeout;
    chk("fl_pre_valid", bus.code_valid, 1);
    flush = 1'b1;
    bus.datain = 14'h0ABC;
    #1;
    chk("fl_ready_low", bus.data_ready, 0);
    tick();
    flush = 1'b0;
    bus.data_valid = 1'b0;
    chk("fl_code_valid", bus.code_valid, 0);
    chk("fl_codeout", bus.codeout, held);
    bus.code_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("fl_s1_cleared", bus.code_valid, 0);
      chk("fl_codeout_hold", bus.codeout, held);
    end
    chk("fl_count", bus.code_count, 16'(exp_count));

    // Random traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      if (!bus.data_valid || acc) begin
        bus.data_valid = ($urandom_range(0, 3) != 0);
        bus.datain = 14'($urandom_range(0, 16383));
      end
      bus.code_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    bus.data_valid = 1'b0;
    bus.code_ready = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    chk("rand_drained", exp_q.size(), 0);
    chk("rand_count", bus.code_count, 16'(exp_count));

    // Asynchronous reset mid-cycle
    bus.datain = 14'h1111; bus.data_valid = 1'b1;
    tick();
    bus.data_valid = 1'b0;
    tick();
    chk("ar_pre_valid", bus.code_valid, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_codeout", bus.codeout, 0);
    chk("ar_code_valid", bus.code_valid, 0);
    chk("ar_code_count", bus.code_count, 0);
    @(posedge clock);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    exp_count = 0;

    // Counter wrap on the 4-bit counter instance
    for (int i = 0; i < 17; i++) begin
      bus4.datain = 14'(i * 97); bus4.data_valid = 1'b1;
      #1;
      chk("wrap_ready", bus4.data_ready, 1);
      @(posedge clock);
      #1;
    end
    bus4.data_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
    end
    chk("wrap_count", bus4.code_count, 17 % 16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/nbcac_encoder_stream_20.md
Name: nbcac_encoder_stream_20

Overview:
- Streaming transmit-side NBCAC encoder for the 20-wire crosstalk-avoidance link.
- Accepts 14-bit data words on a valid/ready handshake and encodes them through the combinational core nbcac_14di_encoder_core (input v[13:0], output d[20:1]).
- Drives registered 20-bit codewords with a valid/ready handshake toward the link driver.
- Two-stage pipeline, full throughput under backpressure, and an accepted-codeword counter for link bring-up.

Parameters:
- DATA_W, 14, data word width; fixed to the core, not to be overridden.
- CODE_W, 20, codeword width; fixed to the core, not to be overridden.
- CNT_W, 16, width of the codeword counter.

Ports:
- clock  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of pipeline valids.
- datain  input  14  data word to encode.
- data_valid  input  1  datain is valid this cycle.
- data_ready  output  1  encoder can accept datain this cycle.
- codeout  output  [20:1]  registered NBCAC codeword.
- code_valid  output  1  codeout holds an unsent codeword.
- code_ready  input  1  downstream accepts codeout this cycle.
- code_count  output  CNT_W  number of codewords handed off (code_valid & code_ready); wraps.

Behaviour:
- Reset (rst_n low, asynchronous):
  - s1_data = 0, s1_valid = 0.
  - codeout = 20'b0, code_valid = 0.
  - code_count = 0.
- Stage 1 (s1): data register plus s1_valid.
- Stage 2 (s2): codeout register plus code_valid.
- Enable equations:
  - s2_load = s1_valid & (~code_valid | code_ready).
  - s1_load = ~s1_valid | s2_load.
  - data_ready = s1_load. This is a combinational path from code_ready and is permitted.
- On each rising edge, if s1_load:
  - s1_data <= datain.
  - s1_valid <= data_valid.
- On each rising edge, if s2_load:
  - codeout <= encoder_core(s1_data).
  - code_valid <= 1.
- On each rising edge, if code_valid & code_ready & ~s2_load: code_valid <= 0.
- codeout is never cleared after reset. When code_valid drops, the last codeword stays on the wires so the bus sees no transitions while idle.
- Latency: a word accepted at edge k (data_valid & data_ready) is on codeout with code_valid = 1 after edge k+1, when unstalled.
- Throughput: one word per cycle while code_ready = 1.
- Stall (code_ready = 0, code_valid = 1):
  - codeout and s1 hold.
  - data_ready = ~s1_valid, so at most one more word is absorbed into s1.
  - No word is lost or duplicated.
- Simultaneous events:
  - In the same cycle, a handoff on s2, a move s1 -> s2 and a new accept into s1 are all legal.
  - Data ordering is strictly FIFO.
- flush (synchronous, highest priority over loads):
  - s1_valid <= 0 and code_valid <= 0.
  - codeout and s1_data hold their values.
  - data_ready = 0 in a flush cycle; the handshake is not honoured.
  - code_count still increments if code_valid & code_ready in that cycle.
- code_count increments by 1 on each edge with code_valid & code_ready; it wraps from 2^CNT_W-1 to 0.
- Reset mid-stream: all in-flight words are discarded and the outputs take their reset values immediately.
- data_valid while data_ready = 0: datain is ignored. The source must hold the word (standard valid/ready rule).
- Encoding correctness: nbcac_14di_decoder_core(codeout) == the original datain for every one of the 16384 values.

Test Plan:
- Reset then single word:
  - Stimulus: datain = 14'h0000, then 14'h3FFF, each accepted at edge k, with code_ready = 1.
  - Required: code_valid rises after edge k+1; codeout decodes to the sent value; code_count = 2.
- Exhaustive streaming:
  - Stimulus: all 16384 values back-to-back, with code_ready = 1.
  - Required: data_ready is constantly 1; 16384 consecutive code_valid cycles; in-order round-trip through the decoder core; code_count = 16384 (16'h4000).
- Backpressure:
  - Stimulus: code_ready = 0 for 5 cycles while words 14'h0001, 14'h0002, 14'h0003 are offered.
  - Required: only 2 are accepted (data_ready falls); codeout holds the 14'h0001 codeword stable; after release, the outputs arrive in order 1, 2, 3 with no duplicates.
- Idle hold:
  - Stimulus: send 14'h2AAA, then no input for 10 cycles.
  - Required: code_valid = 0, and codeout keeps the 14'h2AAA codeword with no bit toggling.
- Flush and async reset:
  - Stimulus: with 2 words in flight, assert flush for 1 cycle.
  - Required: both valids are 0 next cycle and codeout is unchanged.
  - Stimulus: assert rst_n = 0 mid-cycle.
  - Required: codeout = 0, code_valid = 0 and code_count = 0 without waiting for a clock edge.
- Counter wrap:
  - Stimulus: CNT_W = 4, send 17 words.
  - Required: code_count = 1.
